// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: control-unit request/status and RAM-side bus of the memory access controller.
interface mem_access_ctrl_if;
   logic        Req;
   logic        ReqWrite;
   logic [2:0]  ReqSize;
   logic [31:0] ReqAddr;
   logic [31:0] ReqData;
   logic        Busy;
   logic        Done;
   logic        Err;
   logic [1:0]  ErrCode;
   logic [31:0] RdData;
   logic        MOV;
   logic        ReadWrite;
   logic [2:0]  MS_2_0;
   logic [31:0] MemAddress;
   logic [31:0] MemDataIn;
   logic        MOCoff;
   logic        MOC;
   logic [31:0] MemDataOut;
   modport slave (
      input  Req, ReqWrite, ReqSize, ReqAddr, ReqData, MOC, MemDataOut,
      output Busy, Done, Err, ErrCode, RdData, MOV, ReadWrite, MS_2_0, MemAddress, MemDataIn, MOCoff
   );
   modport master (
      output Req, ReqWrite, ReqSize, ReqAddr, ReqData, MOC, MemDataOut,
      input  Busy, Done, Err, ErrCode, RdData, MOV, ReadWrite, MS_2_0, MemAddress, MemDataIn, MOCoff
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: Moore FSM sequencing one RAM access per request with MOC handshake, alignment checks and timeout.
module mem_access_ctrl #(
   parameter int TIMEOUT = 8
) (
   input logic              Clk,
   input logic              nReset,
   mem_access_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CLEAR, DONE, ERR} state_t;
   localparam logic [7:0] TO_M1 = 8'(TIMEOUT - 1);
   state_t      state;
   logic [31:0] mar, mdr, rd_data;
   logic        wr;
   logic [2:0]  size;
   logic [7:0]  cnt;
   logic [1:0]  err_code;
   assign bus.Busy       = state inside {ISSUE, WAIT, CLEAR};
   assign bus.MOV        = state == WAIT;
   assign bus.MOCoff     = state inside {CLEAR, ERR};
   assign bus.Done       = state == DONE;
   assign bus.Err        = state == ERR;
   assign bus.ErrCode    = err_code;
   assign bus.RdData     = rd_data;
   assign bus.ReadWrite  = ~wr;
   assign bus.MS_2_0     = size;
   assign bus.MemAddress = mar;
   assign bus.MemDataIn  = mdr;
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state    <= IDLE;
         mar      <= '0;
         mdr      <= '0;
         rd_data  <= '0;
         wr       <= 1'b0;
         size     <= '0;
         cnt      <= '0;
         err_code <= '0;
      end else begin
         case (state)
            IDLE: if (bus.Req) begin
               mar  <= bus.ReqAddr;
               mdr  <= bus.ReqData;
               wr   <= bus.ReqWrite;
               size <= bus.ReqSize;
               if (bus.ReqSize[1:0] == 2'b11) begin
                  err_code <= 2'b10;
                  state    <= ERR;
               end else if ((bus.ReqSize[1:0] == 2'b01 && bus.ReqAddr[0]) ||
                            (bus.ReqSize[1:0] == 2'b10 && bus.ReqAddr[1:0] != 2'b00)) begin
                  err_code <= 2'b01;
                  state    <= ERR;
               end else state <= ISSUE;
            end
            ISSUE: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: if (bus.MOC) begin
               if (!wr) rd_data <= bus.MemDataOut;
               state <= CLEAR;
            end else if (cnt == TO_M1) begin
               err_code <= 2'b11;
               state    <= ERR;
            end else cnt <= cnt + 8'd1;
            CLEAR: if (!bus.MOC) state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8, giving the maximum number of WAIT cycles allowed for MOC before the access is aborted (legal range 1..255).
REQ-002 SHALL have one clock and an asynchronous active-low reset: ports Clk (in, 1, rising-edge clock) and nReset (in, 1, asynchronous active-low reset).
REQ-003 SHALL have these request ports from the control unit:
- Req (in, 1): access request.
- ReqWrite (in, 1): 1 = write, 0 = read.
- ReqSize (in, 3): bit2 = sign-extend; bits1:0 = 00 byte, 01 halfword, 10 word.
- ReqAddr (in, 32): byte address.
- ReqData (in, 32): write data.
REQ-004 SHALL have these status ports to the control unit:
- Busy (out, 1): access in progress.
- Done (out, 1): one-cycle completion pulse.
- Err (out, 1): one-cycle abort pulse.
- ErrCode (out, 2): abort cause.
- RdData (out, 32): captured read data.
REQ-005 SHALL have these RAM-side ports:
- MOV (out, 1): memory operation valid.
- ReadWrite (out, 1): 1 = read, 0 = write.
- MS_2_0 (out, 3): size/sign field.
- MemAddress (out, 32): address.
- MemDataIn (out, 32): write data to RAM.
- MOCoff (out, 1): MOC clear request.
- MOC (in, 1): operation complete.
- MemDataOut (in, 32): read data from RAM.

Function
REQ-006 SHALL implement a Moore FSM with states IDLE, ISSUE, WAIT, CLEAR, DONE and ERR; every output SHALL be registered or decoded from state and registers only.
REQ-007 SHALL, in IDLE, drive Busy=0 and accept a request on a rising edge with Req=1, latching ReqAddr into MAR, ReqData into MDR, ReqWrite and ReqSize.
REQ-008 SHALL, on accept, go to ERR with ErrCode=10 if ReqSize[1:0]=11.
REQ-009 SHALL otherwise, on accept, go to ERR with ErrCode=01 if the access is a halfword with Addr[0]=1 or a word with Addr[1:0]!=00.
REQ-010 SHALL otherwise, on accept, go to ISSUE.
REQ-011 SHALL drive Busy=1 in ISSUE, WAIT and CLEAR, and SHALL ignore Req in every state except IDLE.
REQ-012 SHALL drive MemAddress=MAR, MemDataIn=MDR, ReadWrite=~write and MS_2_0=latched size from ISSUE through CLEAR; MOV SHALL stay 0 in ISSUE (one cycle of address/data setup).
REQ-013 SHALL leave ISSUE unconditionally after one cycle for WAIT, clearing the timeout counter.
REQ-014 SHALL hold MOV=1 throughout WAIT and sample MOC on every rising edge in WAIT.
REQ-015 SHALL, when MOC=1 is sampled in WAIT, load RdData<=MemDataOut for a read (RdData unchanged for a write) and go to CLEAR.
REQ-016 SHALL, when MOC=0 is sampled in WAIT, increment the counter; when the counter reaches TIMEOUT-1 with MOC still 0, it SHALL go to ERR with ErrCode=11.
REQ-017 SHALL, in CLEAR, drive MOV=0 and MOCoff=1, remain in CLEAR while MOC=1, and go to DONE on the first edge sampling MOC=0.
REQ-018 SHALL, in DONE, drive Done=1 for exactly one cycle, then return to IDLE.
REQ-019 SHALL, in ERR, drive Err=1 for exactly one cycle with MOV=0 and MOCoff=1, then return to IDLE; ErrCode SHALL hold its value until the next ERR entry.
REQ-020 SHALL never assert Done and Err in the same cycle, and SHALL never assert MOV when entering via ERR (no RAM access for a rejected request).
REQ-021 SHALL treat a request in the IDLE cycle right after DONE or ERR as a normal new request; there are no dead cycles between accesses.
REQ-022 SHALL, if MOC is already 1 at entry to WAIT, take the MOC=1 path on the first WAIT edge (minimum latency).

Reset
REQ-023 SHALL, on nReset=0 and independent of Clk, force state IDLE and set MOV, MOCoff, Busy, Done, Err, ReqWrite latch and counter to 0, ErrCode to 00, RdData/MAR/MDR to 0, and ReadWrite to 1 (read).
REQ-024 SHALL, on reset mid-access (any non-IDLE state), drop MOV immediately and discard the access with no Done or Err pulse; after release, the first access starts from IDLE.

Verification
REQ-025 SHALL be tested with a word write to 0x10 with ReqData=0xDEADBEEF, where the RAM returns MOC in the first WAIT cycle -> MOV high for exactly one cycle, Done pulses 4 cycles after the accept edge, and Err stays 0.
REQ-026 SHALL be tested with a word read of 0x10 after that write, with MemDataOut=0xDEADBEEF -> RdData=0xDEADBEEF when Done=1, and ReadWrite=1 throughout.
REQ-027 SHALL be tested with a halfword request at 0x11, and separately with ReqSize=3'b011 -> Err pulses with ErrCode 01 and 10 respectively, MOV never rises, and Busy stays 0.
REQ-028 SHALL be tested with MOC held at 0 and TIMEOUT=8 -> MOV high for 8 cycles, then Err with ErrCode=11, then MOCoff=1 for one cycle.
REQ-029 SHALL be tested with MOC held at 1 for 3 cycles after MOCoff rises -> the FSM stays in CLEAR for those 3 cycles and Done follows only after MOC=0.
REQ-030 SHALL be tested with nReset pulsed low during WAIT -> MOV=0 within the same time step, no Done or Err pulse, and the next request completes normally.
